ram_access_arbiter: RTL
=======================

Name: ram_access_arbiter

Overview:
- Parametrised successor of the per-table RAM read/write arbiter in the controller interactive module.
- Arbitrates one write requester and one read requester onto a single-port table RAM; write wins on collision.
- Unlike the previous generation, a losing read is parked in a one-entry pending slot and reissued, not dropped.
- Also returns read data aligned to a configurable RAM latency and counts conflicts. One instance per mapping table (5tuple, regroup, ...).

Parameters:
AW, 8, RAM address width
DW, 71, RAM data width
RAM_LAT, 2, RAM read latency in cycles from o_ram_rd-high cycle to iv_ram_rdata valid (>=1)
CNT_W, 16, conflict counter width
STARVE_MAX, 4, max consecutive deferrals of the pending read (used only with the optional feature, >=1)

Ports:
i_clk  in  1  clock
i_rst  in  1  reset
i_wr_req  in  1  write request
iv_wr_addr  in  AW  write address
iv_wr_data  in  DW  write data
o_wr_ready  out  1  write accepted when i_wr_req & o_wr_ready
i_rd_req  in  1  read request
iv_rd_addr  in  AW  read address
o_rd_ready  out  1  read accepted when i_rd_req & o_rd_ready
ov_ram_addr  out  AW  RAM address
ov_ram_wdata  out  DW  RAM write data
o_ram_wr  out  1  RAM write strobe
o_ram_rd  out  1  RAM read strobe
iv_ram_rdata  in  DW  RAM read data
ov_rdata  out  DW  returned read data
o_rdata_valid  out  1  ov_rdata valid pulse
o_conflict  out  1  conflict pulse
i_cnt_clr  in  1  clear conflict counter
ov_conflict_cnt  out  CNT_W  saturating conflict count

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is synchronous and active-high.
- Reset values: every registered output is 0, the pending slot is empty, the starve count is 0, and the latency pipe is cleared.
- o_rd_ready = !pend_valid, driven from a register only. It is 1 out of reset.
- o_wr_ready = 1, except under the optional feature. Neither ready depends combinationally on a request.
- Read candidate each cycle:
  - the pending slot if pend_valid;
  - otherwise the incoming read if i_rd_req.
- Write candidate: i_wr_req & o_wr_ready.
- Issue (registered, 1-cycle latency):
  - Write candidate present: ov_ram_addr=iv_wr_addr, ov_ram_wdata=iv_wr_data, o_ram_wr=1, o_ram_rd=0.
  - Only a read candidate present: ov_ram_addr=read address, ov_ram_wdata=0, o_ram_rd=1, o_ram_wr=0.
  - Neither present: addr, wdata and strobes all 0.
- Conflict (write and read candidates in the same cycle):
  - The write issues.
  - If the read candidate came from the input, it is stored into the pending slot (pend_valid=1); a read from the slot stays there.
  - o_conflict pulses in the same cycle as that o_ram_wr.
  - ov_conflict_cnt increments and saturates at all-ones.
- Pending slot is cleared in the cycle its read issues. While it is full, o_rd_ready=0, so no new read is accepted. Reads complete strictly in acceptance order.
- Same-address hazard: a read deferred behind a write to the same address returns the newly written data. This is a natural consequence of the ordering; no bypass is needed.
- Read return:
  - A RAM_LAT-deep shift pipe tracks o_ram_rd.
  - When the pipe output is 1, iv_ram_rdata is registered into ov_rdata and o_rdata_valid pulses for 1 cycle.
  - End-to-end latency, read accepted at cycle 0 with no conflict: o_ram_rd at cycle 1, o_rdata_valid at cycle RAM_LAT+2.
  - Each deferral cycle adds 1 cycle.
  - ov_rdata holds its last value between pulses.
- i_cnt_clr zeroes the counter next cycle. If it coincides with a conflict, the counter ends at 0.
- Reset mid-operation: the pending read and in-flight reads are discarded, and no o_rdata_valid follows reset.

Optional Feature:
RAM_ARB_STARVE_GUARD_EN
- Defined:
  - A starve count increments on every cycle the pending read is deferred by a write, and clears when the pending read issues.
  - When starve count == STARVE_MAX and pend_valid: o_wr_ready=0 for that cycle. The pending read issues, and the write requester must hold its request and data.
  - o_conflict does not pulse in that cycle.
  - This bounds read wait to STARVE_MAX+1 cycles.
- Undefined: o_wr_ready is tied to 1, and back-to-back writes can starve the pending read indefinitely.

Test Plan:
- Reset, then a lone read of addr 0x05 at cycle 0 (RAM model returns 0xAA) -> o_ram_rd=1 with addr 0x05 at cycle 1; o_rdata_valid=1 with ov_rdata=0xAA at cycle 4 (RAM_LAT=2); o_conflict stays 0.
- Write 0x12→addr 0x05 together with a read of 0x05 at cycle 0 -> cycle 1: o_ram_wr=1 addr 0x05, o_conflict=1, cnt=1, o_rd_ready=0. Cycle 2: o_ram_rd=1 addr 0x05. Cycle 5: ov_rdata=0x12.
- Read held pending while i_rd_req stays high with new addr 0x07 -> 0x07 is not accepted until o_rd_ready returns to 1; both reads return in order.
- Counter: force 2^CNT_W+3 conflicts -> ov_conflict_cnt saturates at all-ones. i_cnt_clr pulse -> 0 next cycle.
- With RAM_ARB_STARVE_GUARD_EN and STARVE_MAX=4, a continuous write stream plus one read -> 4 deferrals, then o_wr_ready=0 for 1 cycle and the read issues on the 5th cycle. Without the macro, the read never issues during the stream.
- Assert i_rst while the pending slot is full and a read is in flight -> next cycle all outputs are 0, o_rd_ready=1, and no o_rdata_valid pulse follows.

Source files
------------

// File: rtl/ram_access_arbiter_if.sv
// -----------------------------------------------------------------------------
// ram_access_arbiter_if
//
// Purpose: bundles the requester-side and RAM-side signals of one
// ram_access_arbiter instance so a mapping-table wrapper can pass them around
// as a single port.
//
// Parameters:
//   AW    - RAM address width
//   DW    - RAM data width
//   CNT_W - conflict counter width
//
// Signal summary (directions seen from the arbiter, modport slave):
//   i_wr_req, iv_wr_addr, iv_wr_data     in   write request/address/data
//   o_wr_ready                           out  write accepted when req & ready
//   i_rd_req, iv_rd_addr                 in   read request/address
//   o_rd_ready                           out  read accepted when req & ready
//   ov_ram_addr, ov_ram_wdata            out  RAM address / write data
//   o_ram_wr, o_ram_rd                   out  RAM write / read strobes
//   iv_ram_rdata                         in   RAM read data
//   ov_rdata, o_rdata_valid              out  returned read data + valid pulse
//   o_conflict                           out  write/read collision pulse
//   i_cnt_clr                            in   clear conflict counter
//   ov_conflict_cnt                      out  saturating conflict count
//   dbg_pend_state                       out  pending-slot FSM state
//                                              (0 = empty, 1 = full)
//
// Modport master is the mirror image, for the block that drives requests and
// models the RAM.
// -----------------------------------------------------------------------------
interface ram_access_arbiter_if #(
  parameter int AW    = 8,
  parameter int DW    = 71,
  parameter int CNT_W = 16
);
  logic             i_wr_req;
  logic [AW-1:0]    iv_wr_addr;
  logic [DW-1:0]    iv_wr_data;
  logic             o_wr_ready;
  logic             i_rd_req;
  logic [AW-1:0]    iv_rd_addr;
  logic             o_rd_ready;
  logic [AW-1:0]    ov_ram_addr;
  logic [DW-1:0]    ov_ram_wdata;
  logic             o_ram_wr;
  logic             o_ram_rd;
  logic [DW-1:0]    iv_ram_rdata;
  logic [DW-1:0]    ov_rdata;
  logic             o_rdata_valid;
  logic             o_conflict;
  logic             i_cnt_clr;
  logic [CNT_W-1:0] ov_conflict_cnt;
  logic             dbg_pend_state;

  modport slave (
    input  i_wr_req, iv_wr_addr, iv_wr_data,
    input  i_rd_req, iv_rd_addr,
    input  iv_ram_rdata,
    input  i_cnt_clr,
    output o_wr_ready, o_rd_ready,
    output ov_ram_addr, ov_ram_wdata, o_ram_wr, o_ram_rd,
    output ov_rdata, o_rdata_valid,
    output o_conflict, ov_conflict_cnt,
    output dbg_pend_state
  );

  modport master (
    output i_wr_req, iv_wr_addr, iv_wr_data,
    output i_rd_req, iv_rd_addr,
    output iv_ram_rdata,
    output i_cnt_clr,
    input  o_wr_ready, o_rd_ready,
    input  ov_ram_addr, ov_ram_wdata, o_ram_wr, o_ram_rd,
    input  ov_rdata, o_rdata_valid,
    input  o_conflict, ov_conflict_cnt,
    input  dbg_pend_state
  );
endinterface

// File: rtl/ram_access_arbiter.sv
// -----------------------------------------------------------------------------
// ram_access_arbiter
//
// Purpose: arbitrates one write requester and one read requester onto a
// single-port table RAM. The write always wins a collision; a losing read is
// parked in a one-entry pending slot and reissued as soon as the RAM is free,
// so reads are never dropped and complete in acceptance order. Read data is
// realigned to the RAM latency and returned with a one-cycle valid pulse.
// Collisions are pulsed on o_conflict and counted in a saturating counter.
// One instance per mapping table.
//
// Parameters:
//   AW         - RAM address width
//   DW         - RAM data width
//   RAM_LAT    - cycles from the o_ram_rd-high cycle to iv_ram_rdata valid (>=1)
//   CNT_W      - conflict counter width
//   STARVE_MAX - max consecutive deferrals of the pending read (starve guard)
//
// Ports:
//   i_clk  - clock
//   i_rst  - synchronous, active-high reset
//   bus    - ram_access_arbiter_if.slave (requests, RAM side, read return,
//            conflict reporting, pending-slot debug state)
//
// Handshake: a request on either side is taken in the cycle where its req
// and ready are both 1 at the rising clock edge; when ready is 0 the
// requester must keep req, address and data stable. Both readies come from
// registered state only and never depend on a request in the same cycle.
//
// Build option: define RAM_ARB_STARVE_GUARD_EN to enable the starve guard.
// With it, once the pending read has been deferred STARVE_MAX times,
// o_wr_ready drops for one cycle so the read issues. Without it, o_wr_ready
// is constant 1 and a continuous write stream can hold the pending read off
// indefinitely.
//
// Latency: a read accepted at cycle 0 without conflict drives o_ram_rd at
// cycle 1 and o_rdata_valid at cycle RAM_LAT+2; each deferral adds a cycle.
// -----------------------------------------------------------------------------
module ram_access_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 71,
  parameter int RAM_LAT    = 2,
  parameter int CNT_W      = 16,
  parameter int STARVE_MAX = 4
) (
  input logic                 i_clk,
  input logic                 i_rst,
  ram_access_arbiter_if.slave bus
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic {
    PEND_EMPTY = 1'b0,
    PEND_FULL  = 1'b1
  } pend_state_t;

  // Pending-slot FSM
  pend_state_t   state;
  pend_state_t   state_next;
  logic [AW-1:0] pend_addr;
  logic [AW-1:0] pend_addr_next;
  logic          rd_ready_q;

  // Candidates for this cycle
  logic          wr_ready;
  logic          wr_cand;
  logic          rd_from_in;
  logic          rd_cand;
  logic [AW-1:0] rd_cand_addr;
  logic          conflict;

  // Issue stage
  logic [AW-1:0] ram_addr_next;
  logic [DW-1:0] ram_wdata_next;
  logic          ram_wr_next;
  logic          ram_rd_next;
  logic [AW-1:0] ram_addr_q;
  logic [DW-1:0] ram_wdata_q;
  logic          ram_wr_q;
  logic          ram_rd_q;
  logic          conflict_q;

  // Starvation tracking and conflict counting
  logic [SW-1:0]    starve_cnt;
  logic [SW-1:0]    starve_next;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_next;

  // Read return alignment
  logic [RAM_LAT-1:0] rd_pipe;
  logic [DW-1:0]      rdata_q;
  logic               rdata_valid_q;

`ifdef RAM_ARB_STARVE_GUARD_EN
  // Hold the writer off for exactly one cycle once the parked read has been
  // passed over STARVE_MAX times; that cycle has no write candidate, so the
  // read issues and no conflict is reported.
  assign wr_ready = !((state == PEND_FULL) && (starve_cnt == SW'(STARVE_MAX)));
`else
  assign wr_ready = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // FSM process 1: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= PEND_EMPTY;
      pend_addr  <= '0;
      rd_ready_q <= 1'b1;
    end else begin
      state      <= state_next;
      pend_addr  <= pend_addr_next;
      // Registered copy of "slot will be empty" so o_rd_ready is a flop.
      rd_ready_q <= (state_next == PEND_EMPTY);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 2: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state;
    pend_addr_next = pend_addr;
    case (state)
      PEND_EMPTY: begin
        // An accepted input read that loses to a write gets parked.
        if (rd_from_in && wr_cand) begin
          state_next     = PEND_FULL;
          pend_addr_next = bus.iv_rd_addr;
        end
      end
      PEND_FULL: begin
        // The parked read issues in any cycle without a write candidate.
        if (!wr_cand) begin
          state_next = PEND_EMPTY;
        end
      end
      default: begin
        state_next = PEND_EMPTY;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM process 3: outputs (candidate selection and next issue values)
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_cand      = bus.i_wr_req & wr_ready;
    rd_from_in   = (state == PEND_EMPTY) & bus.i_rd_req & rd_ready_q;
    // The parked read always has priority over a new one; while the slot is
    // full o_rd_ready is 0 so no new read can arrive anyway.
    rd_cand      = (state == PEND_FULL) | rd_from_in;
    rd_cand_addr = (state == PEND_FULL) ? pend_addr : bus.iv_rd_addr;
    conflict     = wr_cand & rd_cand;

    ram_addr_next  = '0;
    ram_wdata_next = '0;
    ram_wr_next    = 1'b0;
    ram_rd_next    = 1'b0;
    if (wr_cand) begin
      ram_addr_next  = bus.iv_wr_addr;
      ram_wdata_next = bus.iv_wr_data;
      ram_wr_next    = 1'b1;
    end else if (rd_cand) begin
      ram_addr_next = rd_cand_addr;
      ram_rd_next   = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Starve count and conflict counter next values
  // ---------------------------------------------------------------------------
  always_comb begin
    // Every collision defers a read (the incoming one being parked, or the
    // parked one waiting again). The count clears once the read issues and
    // saturates so it stays in range when the guard is not built in.
    starve_next = starve_cnt;
    if (conflict) begin
      if (starve_cnt != SW'(STARVE_MAX)) begin
        starve_next = starve_cnt + 1'b1;
      end
    end else if (rd_cand) begin
      starve_next = '0;
    end

    // Clear has priority over a coincident conflict.
    cnt_next = cnt_q;
    if (bus.i_cnt_clr) begin
      cnt_next = '0;
    end else if (conflict && (cnt_q != '1)) begin
      cnt_next = cnt_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Issue registers, counters and read return
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
      ram_wr_q      <= 1'b0;
      ram_rd_q      <= 1'b0;
      conflict_q    <= 1'b0;
      starve_cnt    <= '0;
      cnt_q         <= '0;
      rd_pipe       <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
    end else begin
      ram_addr_q  <= ram_addr_next;
      ram_wdata_q <= ram_wdata_next;
      ram_wr_q    <= ram_wr_next;
      ram_rd_q    <= ram_rd_next;
      conflict_q  <= conflict;
      starve_cnt  <= starve_next;
      cnt_q       <= cnt_next;

      // rd_pipe[RAM_LAT-1] is high exactly in the cycle the RAM presents the
      // data for a strobe issued RAM_LAT cycles earlier.
      rd_pipe[0] <= ram_rd_q;
      for (int k = 1; k < RAM_LAT; k++) begin
        rd_pipe[k] <= rd_pipe[k-1];
      end

      rdata_valid_q <= rd_pipe[RAM_LAT-1];
      if (rd_pipe[RAM_LAT-1]) begin
        rdata_q <= bus.iv_ram_rdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output drive
  // ---------------------------------------------------------------------------
  assign bus.o_wr_ready      = wr_ready;
  assign bus.o_rd_ready      = rd_ready_q;
  assign bus.ov_ram_addr     = ram_addr_q;
  assign bus.ov_ram_wdata    = ram_wdata_q;
  assign bus.o_ram_wr        = ram_wr_q;
  assign bus.o_ram_rd        = ram_rd_q;
  assign bus.ov_rdata        = rdata_q;
  assign bus.o_rdata_valid   = rdata_valid_q;
  assign bus.o_conflict      = conflict_q;
  assign bus.ov_conflict_cnt = cnt_q;
  assign bus.dbg_pend_state  = (state == PEND_FULL);

endmodule
